regfile_write_arbiter: RTL

- Shares the register file's single write port between several write-back requesters (ALU write-back, mult/div completion, status/exception writer).
- Arbitrates among valid requests using valid/ready handshakes.
- Registers the winning write one cycle before it reaches the regfile's ctrl_writeEnable, ctrl_writeReg and data_writeReg inputs.
- Reports which register currently has a write in flight, for hazard logic.

---
 rtl/regfile_wb_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/regfile_write_arbiter.sv | 76 +++++++
 3 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared register-file write-back definitions: geometry and default requester IDs.
package regfile_wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam int REQ_ALU     = 0;
  localparam int REQ_MULTDIV = 1;
  localparam int REQ_STATUS  = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter for the write-back port; round-robin by default,
// fixed lowest-index priority when ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               hold,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         grant_idx
);
  import regfile_wb_pkg::*;

  int   idx;
  logic found;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (!hold && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = k;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = idx[1:0];
        end
      end
    end
  end
`else
  logic [1:0] rr_ptr;

  // Search starts at rr_ptr and wraps, so the last winner drops to lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (!hold && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQ;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = idx[1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (advance)
      rr_ptr <= (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
  end
`endif
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates write-back requesters onto the single regfile write port and stages
// the winner one cycle. Optional macro: ARB_FIXED_PRIO_EN (fixed priority).
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      ctrl_hold,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic [1:0]                grant_id,
  output logic [31:0]               pending_mask
);
  import regfile_wb_pkg::*;

  logic [NUM_REQ-1:0] grant_p0;
  logic [1:0]         gidx_p0;
  logic               xfer_p0;
  logic [ADDR_W-1:0]  sel_reg_p0;
  logic [DATA_W-1:0]  sel_data_p0;

  logic               vld_p1;
  logic [ADDR_W-1:0]  reg_p1;
  logic [DATA_W-1:0]  data_p1;
  logic [1:0]         gid_p1;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clock),
    .rst       (ctrl_reset),
    .req       (req_valid),
    .hold      (ctrl_hold),
    .advance   (xfer_p0),
    .grant     (grant_p0),
    .grant_idx (gidx_p0)
  );

  assign req_ready   = grant_p0;
  assign xfer_p0     = |(req_valid & grant_p0);
  assign sel_reg_p0  = req_reg[int'(gidx_p0)*ADDR_W +: ADDR_W];
  assign sel_data_p0 = req_data[int'(gidx_p0)*DATA_W +: DATA_W];

  // p0 -> p1: stage the winning write; r0 writes complete the handshake but never enable.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      vld_p1  <= 1'b0;
      reg_p1  <= '0;
      data_p1 <= '0;
      gid_p1  <= '0;
    end else begin
      vld_p1 <= xfer_p0 && (sel_reg_p0 != ADDR_W'(REG_ZERO));
      if (xfer_p0) begin
        reg_p1  <= sel_reg_p0;
        data_p1 <= sel_data_p0;
        gid_p1  <= gidx_p0;
      end
    end
  end

  assign ctrl_writeEnable = vld_p1;
  assign ctrl_writeReg    = reg_p1;
  assign data_writeReg    = data_p1;
  assign grant_id         = gid_p1;

  always_comb begin
    pending_mask = '0;
    if (vld_p1)
      pending_mask[reg_p1] = 1'b1;
  end
endmodule
